press_classifier: RTL and testbench

Classifies debounced push-button activity into single-cycle event pulses: short press, long press and double click. Sits directly downstream of the switch debouncer and consumes its debounced level. Its outputs drive menu/mode logic, so downstream logic never times button gestures itself.

---
 rtl/press_pkg.sv | 16 +
 rtl/event_timer.sv | 35 +++
 rtl/press_classifier.sv | 148 ++++++++++++++
 tb/tb_press_classifier.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/press_pkg.sv
// Shared types and helpers for the push-button gesture classifier.
package press_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    LONG_HELD = 3'd2,
    WAIT_GAP  = 3'd3,
    SECOND    = 3'd4
  } state_e;

  function automatic int ms_to_cycles(input int clk_rate, input int ms);
    return clk_rate / 1000 * ms;
  endfunction

endpackage

// File: rtl/event_timer.sv
// Clearable, enabled up-counter with terminal-count compare against a run-time limit.
module event_timer #(
  parameter int CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [CntW-1:0] limit_i,
  output logic            tc_o
);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/press_classifier.sv
// Turns a debounced button level into short / long / double-click pulses.
// DOUBLE_CLICK_EN enables the release gap window and double-click detection.
module press_classifier
  import press_pkg::*;
#(
  parameter int ClkRate = 10_000_000,
  parameter int LongMs  = 500,
  parameter int GapMs   = 250
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic short_o,
  output logic long_o,
  output logic double_o,
  output logic busy_o
);

  localparam int LongCycles = ms_to_cycles(ClkRate, LongMs);
  localparam int GapCycles  = ms_to_cycles(ClkRate, GapMs);
  localparam int MaxCycles  = (LongCycles > GapCycles) ? LongCycles : GapCycles;
  localparam int CntW       = $clog2(MaxCycles);
  localparam logic [CntW-1:0] LongLimit = CntW'(LongCycles - 1);
`ifdef DOUBLE_CLICK_EN
  localparam logic [CntW-1:0] GapLimit  = CntW'(GapCycles - 1);
`endif

  if (LongCycles < 2 || GapCycles < 2) begin : g_cfg_check
    $error("press_classifier: LongCycles and GapCycles must both be >= 2");
  end

  state_e          state_q, state_d;
  logic            lvl_q;
  logic            short_q, short_d;
  logic            long_q, long_d;
  logic            busy_q, busy_d;
  logic            rise, fall;
  logic            tmr_clr, tmr_en, tmr_tc;
  logic [CntW-1:0] tmr_limit;

  assign rise = level_i & ~lvl_q;
  assign fall = ~level_i & lvl_q;

`ifdef DOUBLE_CLICK_EN
  logic double_q, double_d;
`endif

  always_comb begin
    state_d   = state_q;
    short_d   = 1'b0;
    long_d    = 1'b0;
`ifdef DOUBLE_CLICK_EN
    double_d  = 1'b0;
`endif
    tmr_en    = 1'b0;
    tmr_limit = LongLimit;
    case (state_q)
      IDLE: begin
        if (rise) state_d = PRESSED;
      end
      // Fall has priority over the long threshold in the same cycle.
      PRESSED: begin
        tmr_en = 1'b1;
        if (fall) begin
`ifdef DOUBLE_CLICK_EN
          state_d = WAIT_GAP;
`else
          short_d = 1'b1;
          state_d = IDLE;
`endif
        end else if (tmr_tc) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (fall) state_d = IDLE;
      end
`ifdef DOUBLE_CLICK_EN
      // A second press beats gap expiry in the same cycle.
      WAIT_GAP: begin
        tmr_en    = 1'b1;
        tmr_limit = GapLimit;
        if (rise) begin
          state_d = SECOND;
        end else if (tmr_tc) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      SECOND: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    tmr_clr = (state_d != state_q);
    busy_d  = (state_d != IDLE);
  end

  event_timer #(
    .CntW(CntW)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .tc_o    (tmr_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lvl_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= level_i;
      short_q <= short_d;
      long_q  <= long_d;
      busy_q  <= busy_d;
    end
  end

`ifdef DOUBLE_CLICK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      double_q <= 1'b0;
    end else begin
      double_q <= double_d;
    end
  end
  assign double_o = double_q;
`else
  assign double_o = 1'b0;
`endif

  assign short_o = short_q;
  assign long_o  = long_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with a cycle-stamped pulse scoreboard.
module tb_press_classifier;

  logic clk = 1'b0;
  logic rst_i;
  logic level_i;
  logic short_o, long_o, double_o, busy_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [2:0] ev;  // {short, long, double}
  } exp_t;
  exp_t exp_q[$];

  localparam logic [2:0] EV_SHORT  = 3'b100;
  localparam logic [2:0] EV_LONG   = 3'b010;
  localparam logic [2:0] EV_DOUBLE = 3'b001;

  press_classifier #(
    .ClkRate(1000),
    .LongMs (10),
    .GapMs  (5)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .level_i (level_i),
    .short_o (short_o),
    .long_o  (long_o),
    .double_o(double_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle: either the expected pulse at this cycle stamp, or silence.
  logic [2:0] obs;
  exp_t       cur;
  always @(negedge clk) begin
    if (mon_en) begin
      obs = {short_o, long_o, double_o};
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        cur = exp_q.pop_front();
        checks++;
        assert (obs === cur.ev) else begin
          errors++;
          $error("FAIL pulse cyc=%0d observed=%b expected=%b", cyc, obs, cur.ev);
        end
      end else begin
        checks++;
        assert (obs === 3'b000) else begin
          errors++;
          $error("FAIL idle_pulse cyc=%0d observed=%b expected=000", cyc, obs);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic push(input int c, input logic [2:0] ev);
    exp_q.push_back('{cyc: c, ev: ev});
  endtask

  initial begin
    int k;
    rst_i   = 1'b1;
    level_i = 1'b0;
    tick(3);
    chk("rst_short", short_o, 1'b0);
    chk("rst_long", long_o, 1'b0);
    chk("rst_double", double_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    rst_i  = 1'b0;
    mon_en = 1'b1;
    tick(3);

    // Long press: held 15 cycles, pulse after E0+10, silent release.
    k = cyc; level_i = 1'b1;
    push(k + 11, EV_LONG);
    tick(1);
    chk("busy_after_rise", busy_o, 1'b1);
    tick(14);
    chk("busy_long_held", busy_o, 1'b1);
    level_i = 1'b0;
    tick(1);
    chk("busy_after_release", busy_o, 1'b0);
    tick(10);

    // Held exactly 11 samples: terminal count reached while still pressed.
    k = cyc; level_i = 1'b1;
    push(k + 11, EV_LONG);
    tick(11);
    level_i = 1'b0;
    tick(10);

    // Fall sampled on the terminal-count edge: short path, no long.
    k = cyc; level_i = 1'b1;
    tick(10);
    level_i = 1'b0;
`ifdef DOUBLE_CLICK_EN
    push(k + 16, EV_SHORT);
`else
    push(k + 11, EV_SHORT);
`endif
    tick(20);
    chk("busy_idle_after_short", busy_o, 1'b0);

    // Reset mid-press with the button held: no pulse, then a fresh count.
    k = cyc; level_i = 1'b1;
    tick(5);
    rst_i = 1'b1;
    tick(2);
    chk("busy_in_reset", busy_o, 1'b0);
    rst_i = 1'b0;
    push(k + 18, EV_LONG);
    tick(1);
    chk("busy_after_reset_rise", busy_o, 1'b1);
    tick(14);
    level_i = 1'b0;
    tick(10);

`ifdef DOUBLE_CLICK_EN
    // Short press: pulse after the gap window expires.
    k = cyc; level_i = 1'b1;
    tick(4);
    level_i = 1'b0;
    push(k + 10, EV_SHORT);
    tick(20);

    // Press 3, release 2, press 3: double click on the second fall.
    k = cyc; level_i = 1'b1;
    tick(3);
    level_i = 1'b0;
    tick(2);
    level_i = 1'b1;
    tick(3);
    level_i = 1'b0;
    push(k + 9, EV_DOUBLE);
    tick(1);
    chk("busy_after_double", busy_o, 1'b0);
    tick(15);

    // Second rise on the gap terminal-count edge still counts as a double.
    k = cyc; level_i = 1'b1;
    tick(3);
    level_i = 1'b0;
    tick(5);
    level_i = 1'b1;
    tick(3);
    level_i = 1'b0;
    push(k + 12, EV_DOUBLE);
    tick(15);

    // Second rise one cycle past the gap: short, then a new independent press.
    k = cyc; level_i = 1'b1;
    tick(3);
    level_i = 1'b0;
    push(k + 9, EV_SHORT);
    tick(6);
    level_i = 1'b1;
    tick(3);
    level_i = 1'b0;
    push(k + 18, EV_SHORT);
    tick(20);
`else
    // Press 3, release 2, press 2: two immediate shorts, no double.
    k = cyc; level_i = 1'b1;
    tick(3);
    level_i = 1'b0;
    push(k + 4, EV_SHORT);
    tick(1);
    chk("busy_after_short", busy_o, 1'b0);
    tick(1);
    level_i = 1'b1;
    tick(2);
    level_i = 1'b0;
    push(k + 8, EV_SHORT);
    tick(20);
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL pending_pulses observed=%0d expected=0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
